// File: rtl/scr1_pipe_mprf_wb.sv
// EXU-side MPRF requester: operand read, ALU/LSU/MDU writeback arbitration and a pending-write scoreboard.
// Latency: source valid to MPRF write request is 1 cycle; operands are combinational from the MPRF read data.
// Backpressure: issue_rdy_o drops on RAW/WAW hazards; LSU/MDU are held off by higher-priority writebacks.
//
// Ports: issue_* (issue request and operand addresses), op_rs*_data_o (operands to EXU),
//        alu_wb_* / lsu_wb_* / mdu_wb_* (writeback sources), exu2mprf_* / mprf2exu_* (MPRF interface),
//        sb_err_o (long writeback to a register the scoreboard did not mark pending).
// Optional macro SCR1_MPRF_WB_BYPASS_EN: forward the write-stage data to the operands instead of
// stalling a dependent issue for the cycle in which the MPRF write is still in flight.

module scr1_pipe_mprf_wb #(
    parameter int XLEN   = 32,
    parameter int AWIDTH = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              issue_vld_i,
    output logic              issue_rdy_o,
    input  logic [AWIDTH-1:0] issue_rs1_addr_i,
    input  logic [AWIDTH-1:0] issue_rs2_addr_i,
    input  logic              issue_rs1_used_i,
    input  logic              issue_rs2_used_i,
    input  logic [AWIDTH-1:0] issue_rd_addr_i,
    input  logic              issue_rd_we_i,
    input  logic              issue_long_i,
    output logic [XLEN-1:0]   op_rs1_data_o,
    output logic [XLEN-1:0]   op_rs2_data_o,

    input  logic              alu_wb_vld_i,
    input  logic [AWIDTH-1:0] alu_wb_rd_i,
    input  logic [XLEN-1:0]   alu_wb_data_i,
    input  logic              lsu_wb_vld_i,
    input  logic [AWIDTH-1:0] lsu_wb_rd_i,
    input  logic [XLEN-1:0]   lsu_wb_data_i,
    output logic              lsu_wb_rdy_o,
    input  logic              mdu_wb_vld_i,
    input  logic [AWIDTH-1:0] mdu_wb_rd_i,
    input  logic [XLEN-1:0]   mdu_wb_data_i,
    output logic              mdu_wb_rdy_o,

    output logic [AWIDTH-1:0] exu2mprf_rs1_addr_o,
    output logic [AWIDTH-1:0] exu2mprf_rs2_addr_o,
    input  logic [XLEN-1:0]   mprf2exu_rs1_data_i,
    input  logic [XLEN-1:0]   mprf2exu_rs2_data_i,
    output logic              exu2mprf_w_req_o,
    output logic [AWIDTH-1:0] exu2mprf_rd_addr_o,
    output logic [XLEN-1:0]   exu2mprf_rd_data_o,

    output logic              sb_err_o
);

    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pending_nxt;

    logic              rs1_inflight;
    logic              rs2_inflight;
    logic              rs1_raw;
    logic              rs2_raw;
    logic              rd_waw;
    logic              issue_fire;

    logic              win_vld;
    logic              win_long;
    logic [AWIDTH-1:0] win_rd;
    logic [XLEN-1:0]   win_data;

    assign exu2mprf_rs1_addr_o = issue_rs1_addr_i;
    assign exu2mprf_rs2_addr_o = issue_rs2_addr_i;

    // A register whose write is sitting in the write stage has already had its
    // pending bit cleared, but the MPRF still returns the old value this cycle.
    assign rs1_inflight = exu2mprf_w_req_o && (exu2mprf_rd_addr_o == issue_rs1_addr_i)
                          && (issue_rs1_addr_i != '0);
    assign rs2_inflight = exu2mprf_w_req_o && (exu2mprf_rd_addr_o == issue_rs2_addr_i)
                          && (issue_rs2_addr_i != '0);

`ifdef SCR1_MPRF_WB_BYPASS_EN
    assign rs1_raw = issue_rs1_used_i && (issue_rs1_addr_i != '0) && pending[issue_rs1_addr_i];
    assign rs2_raw = issue_rs2_used_i && (issue_rs2_addr_i != '0) && pending[issue_rs2_addr_i];
    assign op_rs1_data_o = rs1_inflight ? exu2mprf_rd_data_o : mprf2exu_rs1_data_i;
    assign op_rs2_data_o = rs2_inflight ? exu2mprf_rd_data_o : mprf2exu_rs2_data_i;
`else
    assign rs1_raw = issue_rs1_used_i && (issue_rs1_addr_i != '0)
                     && (pending[issue_rs1_addr_i] || rs1_inflight);
    assign rs2_raw = issue_rs2_used_i && (issue_rs2_addr_i != '0)
                     && (pending[issue_rs2_addr_i] || rs2_inflight);
    assign op_rs1_data_o = mprf2exu_rs1_data_i;
    assign op_rs2_data_o = mprf2exu_rs2_data_i;
`endif

    assign rd_waw      = issue_rd_we_i && (issue_rd_addr_i != '0) && pending[issue_rd_addr_i];
    assign issue_rdy_o = ~(rs1_raw | rs2_raw | rd_waw);
    assign issue_fire  = issue_vld_i & issue_rdy_o;

    // Fixed priority ALU > LSU > MDU; ALU cannot be stalled.
    assign lsu_wb_rdy_o = ~alu_wb_vld_i;
    assign mdu_wb_rdy_o = ~alu_wb_vld_i & ~lsu_wb_vld_i;

    always_comb begin
        win_vld  = 1'b0;
        win_long = 1'b0;
        win_rd   = '0;
        win_data = '0;
        if (alu_wb_vld_i) begin
            win_vld  = 1'b1;
            win_rd   = alu_wb_rd_i;
            win_data = alu_wb_data_i;
        end else if (lsu_wb_vld_i) begin
            win_vld  = 1'b1;
            win_long = 1'b1;
            win_rd   = lsu_wb_rd_i;
            win_data = lsu_wb_data_i;
        end else if (mdu_wb_vld_i) begin
            win_vld  = 1'b1;
            win_long = 1'b1;
            win_rd   = mdu_wb_rd_i;
            win_data = mdu_wb_data_i;
        end
    end

    // Clear from an accepted long writeback and set from a long issue may hit
    // different registers on the same edge; both take effect.
    always_comb begin
        pending_nxt = pending;
        if (win_long && (win_rd != '0)) begin
            pending_nxt[win_rd] = 1'b0;
        end
        if (issue_fire && issue_long_i && issue_rd_we_i && (issue_rd_addr_i != '0)) begin
            pending_nxt[issue_rd_addr_i] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending            <= '0;
            exu2mprf_w_req_o   <= 1'b0;
            exu2mprf_rd_addr_o <= '0;
            exu2mprf_rd_data_o <= '0;
            sb_err_o           <= 1'b0;
        end else begin
            pending          <= pending_nxt;
            exu2mprf_w_req_o <= win_vld && (win_rd != '0);
            if (win_vld) begin
                exu2mprf_rd_addr_o <= win_rd;
                exu2mprf_rd_data_o <= win_data;
            end
            sb_err_o <= win_long && (win_rd != '0) && !pending[win_rd];
        end
    end

endmodule

// File: tb/tb_scr1_pipe_mprf_wb.sv
module tb_scr1_pipe_mprf_wb;

`ifdef SCR1_MPRF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        issue_vld, issue_rdy, rs1_used, rs2_used, rd_we, is_long;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] op1, op2;
    logic        alu_vld, lsu_vld, mdu_vld, lsu_rdy, mdu_rdy;
    logic [4:0]  alu_rd, lsu_rd, mdu_rd;
    logic [31:0] alu_dat, lsu_dat, mdu_dat;
    logic [4:0]  m_rs1_addr, m_rs2_addr;
    logic [31:0] m_rs1_dat, m_rs2_dat;
    logic        w_req, sb_err;
    logic [4:0]  w_addr;
    logic [31:0] w_dat;

    scr1_pipe_mprf_wb dut (
        .clk(clk), .rst(rst),
        .issue_vld_i(issue_vld), .issue_rdy_o(issue_rdy),
        .issue_rs1_addr_i(rs1), .issue_rs2_addr_i(rs2),
        .issue_rs1_used_i(rs1_used), .issue_rs2_used_i(rs2_used),
        .issue_rd_addr_i(rd), .issue_rd_we_i(rd_we), .issue_long_i(is_long),
        .op_rs1_data_o(op1), .op_rs2_data_o(op2),
        .alu_wb_vld_i(alu_vld), .alu_wb_rd_i(alu_rd), .alu_wb_data_i(alu_dat),
        .lsu_wb_vld_i(lsu_vld), .lsu_wb_rd_i(lsu_rd), .lsu_wb_data_i(lsu_dat), .lsu_wb_rdy_o(lsu_rdy),
        .mdu_wb_vld_i(mdu_vld), .mdu_wb_rd_i(mdu_rd), .mdu_wb_data_i(mdu_dat), .mdu_wb_rdy_o(mdu_rdy),
        .exu2mprf_rs1_addr_o(m_rs1_addr), .exu2mprf_rs2_addr_o(m_rs2_addr),
        .mprf2exu_rs1_data_i(m_rs1_dat), .mprf2exu_rs2_data_i(m_rs2_dat),
        .exu2mprf_w_req_o(w_req), .exu2mprf_rd_addr_o(w_addr), .exu2mprf_rd_data_o(w_dat),
        .sb_err_o(sb_err)
    );

    // MPRF stub driven by the DUT write port; x0 reads as zero.
    logic [31:0] mprf [0:31];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mprf[i] <= 32'h0;
        end else if (w_req) begin
            mprf[w_addr] <= w_dat;
        end
    end
    assign m_rs1_dat = (m_rs1_addr == 5'd0) ? 32'h0 : mprf[m_rs1_addr];
    assign m_rs2_dat = (m_rs2_addr == 5'd0) ? 32'h0 : mprf[m_rs2_addr];

    // Reference model: architectural register values, a set of registers awaiting
    // a long result, and the single write that is on its way into the MPRF.
    bit          m_pend [0:31];
    logic [31:0] m_rf   [0:31];
    bit          m_wreq;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_err;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic bit m_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (m_pend[a]) return 1'b1;
        return !BYP && m_wreq && (m_waddr == a);
    endfunction

    function automatic bit m_rdy();
        if (rs1_used && m_busy(rs1)) return 1'b0;
        if (rs2_used && m_busy(rs2)) return 1'b0;
        if (rd_we && rd != 5'd0 && m_pend[rd]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_op(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (BYP && m_wreq && m_waddr == a) return m_wdata;
        return m_rf[a];
    endfunction

    // Advance one clock, moving the model in step with the DUT.
    task automatic tick();
        bit          fire;
        bit          wv, wl;
        logic [4:0]  wr;
        logic [31:0] wd;
        fire = issue_vld && m_rdy();
        wv = 1'b1; wl = 1'b1; wr = 5'd0; wd = 32'h0;
        if (alu_vld)      begin wl = 1'b0; wr = alu_rd; wd = alu_dat; end
        else if (lsu_vld) begin wr = lsu_rd; wd = lsu_dat; end
        else if (mdu_vld) begin wr = mdu_rd; wd = mdu_dat; end
        else wv = 1'b0;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_pend[i] = 1'b0; m_rf[i] = 32'h0; end
            m_wreq = 1'b0; m_waddr = 5'd0; m_wdata = 32'h0; m_err = 1'b0;
        end else begin
            if (m_wreq) m_rf[m_waddr] = m_wdata;
            m_err = wv && wl && wr != 5'd0 && !m_pend[wr];
            if (wv && wl && wr != 5'd0) m_pend[wr] = 1'b0;
            if (fire && is_long && rd_we && rd != 5'd0) m_pend[rd] = 1'b1;
            m_wreq = wv && wr != 5'd0;
            if (wv) begin m_waddr = wr; m_wdata = wd; end
        end
    endtask

    task automatic idle_inputs();
        issue_vld = 0; rs1_used = 0; rs2_used = 0; rd_we = 0; is_long = 0;
        rs1 = 0; rs2 = 0; rd = 0;
        alu_vld = 0; lsu_vld = 0; mdu_vld = 0;
        alu_rd = 0; lsu_rd = 0; mdu_rd = 0;
        alu_dat = 0; lsu_dat = 0; mdu_dat = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        n_chk++; if (w_req !== 1'b0) $display("FAIL rst_wreq: got %b want 0", w_req); else n_pass++;
        n_chk++; if (w_addr !== 5'd0) $display("FAIL rst_waddr: got %0d want 0", w_addr); else n_pass++;
        n_chk++; if (w_dat !== 32'h0) $display("FAIL rst_wdata: got %h want 0", w_dat); else n_pass++;
        n_chk++; if (sb_err !== 1'b0) $display("FAIL rst_sberr: got %b want 0", sb_err); else n_pass++;
        rst = 0;
        tick();
        n_chk++; if (w_req !== 1'b0) $display("FAIL idle_wreq: got %b want 0", w_req); else n_pass++;
        n_chk++; if (lsu_rdy !== 1'b1 || mdu_rdy !== 1'b1)
            $display("FAIL idle_wb_rdy: got lsu=%b mdu=%b want 1 1", lsu_rdy, mdu_rdy); else n_pass++;
        // No register may look pending after reset.
        for (int i = 0; i < 32; i++) begin
            issue_vld = 1; rs1 = i[4:0]; rs2 = i[4:0]; rd = i[4:0];
            rs1_used = 1; rs2_used = 1; rd_we = 1;
            #1;
            n_chk++; if (issue_rdy !== 1'b1) $display("FAIL rst_pending_x%0d: rdy got %b want 1", i, issue_rdy); else n_pass++;
        end
        idle_inputs();
        issue_vld = 1; rs1 = 5'd3; rs2 = 5'd4; rs1_used = 1; rs2_used = 1;
        #1;
        n_chk++; if (issue_rdy !== 1'b1) $display("FAIL rst_rdy_r3r4: got %b want 1", issue_rdy); else n_pass++;
        idle_inputs();
        tick();
    endtask

    task automatic test_alu_raw();
        idle_inputs();
        issue_vld = 1; rd = 5'd5; rd_we = 1;
        alu_vld = 1; alu_rd = 5'd5; alu_dat = 32'hDEADBEEF;
        #1;
        n_chk++; if (issue_rdy !== 1'b1) $display("FAIL alu_issue_rdy: got %b want 1", issue_rdy); else n_pass++;
        tick();
        idle_inputs();
        issue_vld = 1; rs1 = 5'd5; rs1_used = 1;
        #1;
        n_chk++; if (w_req !== 1'b1 || w_addr !== 5'd5 || w_dat !== 32'hDEADBEEF)
            $display("FAIL alu_write: got req=%b a=%0d d=%h want 1 5 deadbeef", w_req, w_addr, w_dat); else n_pass++;
        n_chk++; if (issue_rdy !== BYP) $display("FAIL alu_dep_rdy: got %b want %b", issue_rdy, BYP); else n_pass++;
        if (BYP) begin
            n_chk++; if (op1 !== 32'hDEADBEEF) $display("FAIL alu_bypass_op: got %h want deadbeef", op1); else n_pass++;
        end
        tick();
        if (!BYP) begin
            #1;
            n_chk++; if (issue_rdy !== 1'b1) $display("FAIL alu_dep_rdy2: got %b want 1", issue_rdy); else n_pass++;
            n_chk++; if (op1 !== 32'hDEADBEEF) $display("FAIL alu_dep_op: got %h want deadbeef", op1); else n_pass++;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_long_load();
        idle_inputs();
        issue_vld = 1; rd = 5'd7; rd_we = 1; is_long = 1;
        #1;
        n_chk++; if (issue_rdy !== 1'b1) $display("FAIL ld_issue_rdy: got %b want 1", issue_rdy); else n_pass++;
        tick();
        idle_inputs();
        issue_vld = 1; rs2 = 5'd7; rs2_used = 1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin lsu_vld = 1; lsu_rd = 5'd7; lsu_dat = 32'h12345678; end
            #1;
            n_chk++; if (issue_rdy !== 1'b0) $display("FAIL ld_dep_held_c%0d: got %b want 0", c, issue_rdy); else n_pass++;
            tick();
        end
        lsu_vld = 0;
        #1;
        n_chk++; if (w_req !== 1'b1 || w_addr !== 5'd7 || w_dat !== 32'h12345678)
            $display("FAIL ld_write: got req=%b a=%0d d=%h want 1 7 12345678", w_req, w_addr, w_dat); else n_pass++;
        n_chk++; if (sb_err !== 1'b0) $display("FAIL ld_sberr: got %b want 0", sb_err); else n_pass++;
        n_chk++; if (issue_rdy !== BYP) $display("FAIL ld_dep_rdy_inflight: got %b want %b", issue_rdy, BYP); else n_pass++;
        if (BYP) begin
            n_chk++; if (op2 !== 32'h12345678) $display("FAIL ld_bypass_op: got %h want 12345678", op2); else n_pass++;
        end
        tick();
        if (!BYP) begin
            #1;
            n_chk++; if (w_req !== 1'b0) $display("FAIL ld_wreq_once: got %b want 0", w_req); else n_pass++;
            n_chk++; if (issue_rdy !== 1'b1) $display("FAIL ld_dep_rdy: got %b want 1", issue_rdy); else n_pass++;
            n_chk++; if (op2 !== 32'h12345678) $display("FAIL ld_dep_op: got %h want 12345678", op2); else n_pass++;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_priority();
        idle_inputs();
        issue_vld = 1; rd_we = 1; is_long = 1; rd = 5'd2;
        tick();
        rd = 5'd3;
        tick();
        idle_inputs();
        alu_vld = 1; alu_rd = 5'd1; alu_dat = 32'h11111111;
        lsu_vld = 1; lsu_rd = 5'd2; lsu_dat = 32'h22222222;
        mdu_vld = 1; mdu_rd = 5'd3; mdu_dat = 32'h33333333;
        #1;
        n_chk++; if (lsu_rdy !== 1'b0 || mdu_rdy !== 1'b0)
            $display("FAIL prio_rdy_all: got lsu=%b mdu=%b want 0 0", lsu_rdy, mdu_rdy); else n_pass++;
        tick();
        alu_vld = 0;
        #1;
        n_chk++; if (w_req !== 1'b1 || w_addr !== 5'd1 || w_dat !== 32'h11111111)
            $display("FAIL prio_w1: got req=%b a=%0d d=%h want 1 1 11111111", w_req, w_addr, w_dat); else n_pass++;
        n_chk++; if (lsu_rdy !== 1'b1 || mdu_rdy !== 1'b0)
            $display("FAIL prio_rdy_lsu: got lsu=%b mdu=%b want 1 0", lsu_rdy, mdu_rdy); else n_pass++;
        tick();
        lsu_vld = 0;
        #1;
        n_chk++; if (w_req !== 1'b1 || w_addr !== 5'd2 || w_dat !== 32'h22222222)
            $display("FAIL prio_w2: got req=%b a=%0d d=%h want 1 2 22222222", w_req, w_addr, w_dat); else n_pass++;
        n_chk++; if (mdu_rdy !== 1'b1) $display("FAIL prio_rdy_mdu: got %b want 1", mdu_rdy); else n_pass++;
        tick();
        mdu_vld = 0;
        #1;
        n_chk++; if (w_req !== 1'b1 || w_addr !== 5'd3 || w_dat !== 32'h33333333)
            $display("FAIL prio_w3: got req=%b a=%0d d=%h want 1 3 33333333", w_req, w_addr, w_dat); else n_pass++;
        n_chk++; if (sb_err !== 1'b0) $display("FAIL prio_sberr: got %b want 0", sb_err); else n_pass++;
        tick();
        n_chk++; if (w_req !== 1'b0) $display("FAIL prio_done: got %b want 0", w_req); else n_pass++;
    endtask

    task automatic test_x0_and_unsolicited();
        idle_inputs();
        issue_vld = 1; rd = 5'd0; rd_we = 1; is_long = 1;
        tick();
        idle_inputs();
        issue_vld = 1; rs1 = 5'd0; rs1_used = 1; rd = 5'd0; rd_we = 1;
        lsu_vld = 1; lsu_rd = 5'd0; lsu_dat = 32'hCAFEF00D;
        #1;
        n_chk++; if (issue_rdy !== 1'b1) $display("FAIL x0_rdy: got %b want 1", issue_rdy); else n_pass++;
        n_chk++; if (op1 !== 32'h0) $display("FAIL x0_op: got %h want 0", op1); else n_pass++;
        tick();
        idle_inputs();
        mdu_vld = 1; mdu_rd = 5'd9; mdu_dat = 32'h0BADF00D;
        #1;
        n_chk++; if (w_req !== 1'b0 || sb_err !== 1'b0)
            $display("FAIL x0_wb: got req=%b err=%b want 0 0", w_req, sb_err); else n_pass++;
        tick();
        mdu_vld = 0;
        #1;
        n_chk++; if (w_req !== 1'b1 || w_addr !== 5'd9 || w_dat !== 32'h0BADF00D)
            $display("FAIL unsol_write: got req=%b a=%0d d=%h want 1 9 0badf00d", w_req, w_addr, w_dat); else n_pass++;
        n_chk++; if (sb_err !== 1'b1) $display("FAIL unsol_sberr: got %b want 1", sb_err); else n_pass++;
        tick();
        n_chk++; if (sb_err !== 1'b0) $display("FAIL unsol_sberr_pulse: got %b want 0", sb_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        issue_vld = 1; rd = 5'd7; rd_we = 1; is_long = 1;
        tick();
        idle_inputs();
        alu_vld = 1; alu_rd = 5'd8; alu_dat = 32'hA5A5A5A5;
        tick();
        idle_inputs();
        issue_vld = 1; rs1 = 5'd7; rs1_used = 1;
        #1;
        n_chk++; if (w_req !== 1'b1 || issue_rdy !== 1'b0)
            $display("FAIL rmid_pre: got req=%b rdy=%b want 1 0", w_req, issue_rdy); else n_pass++;
        rst = 1;
        tick();
        rst = 0;
        #1;
        n_chk++; if (w_req !== 1'b0) $display("FAIL rmid_wreq: got %b want 0", w_req); else n_pass++;
        n_chk++; if (issue_rdy !== 1'b1) $display("FAIL rmid_rdy_rs1: got %b want 1", issue_rdy); else n_pass++;
        rs1_used = 0; rd = 5'd7; rd_we = 1;
        #1;
        n_chk++; if (issue_rdy !== 1'b1) $display("FAIL rmid_rdy_rd: got %b want 1", issue_rdy); else n_pass++;
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [31:0] r;
        bit          e_rdy;
        for (int c = 0; c < 600; c++) begin
            idle_inputs();
            r = $urandom;
            rst       = (r[7:0] == 8'd0);
            issue_vld = r[8] | r[9];
            rs1_used  = r[10];
            rs2_used  = r[11];
            rd_we     = r[12] | r[13];
            is_long   = r[14] & r[15];
            rs1       = {2'b00, r[18:16]};
            rs2       = {2'b00, r[21:19]};
            rd        = {2'b00, r[24:22]};
            lsu_vld   = r[25] & r[26];
            mdu_vld   = r[27] & r[28];
            r = $urandom;
            lsu_rd  = {2'b00, r[2:0]};
            mdu_rd  = {2'b00, r[5:3]};
            alu_rd  = rd;
            lsu_dat = $urandom;
            mdu_dat = $urandom;
            alu_dat = $urandom;
            e_rdy = m_rdy();
            // ALU result accompanies a firing short op that writes rd.
            alu_vld = issue_vld && e_rdy && !is_long && rd_we;
            #1;
            n_chk++; if (issue_rdy !== e_rdy) $display("FAIL rnd_rdy c%0d: got %b want %b", c, issue_rdy, e_rdy); else n_pass++;
            n_chk++; if (lsu_rdy !== !alu_vld || mdu_rdy !== (!alu_vld && !lsu_vld))
                $display("FAIL rnd_wb_rdy c%0d: got lsu=%b mdu=%b", c, lsu_rdy, mdu_rdy); else n_pass++;
            n_chk++; if (op1 !== m_op(rs1) || op2 !== m_op(rs2))
                $display("FAIL rnd_op c%0d: got %h %h want %h %h", c, op1, op2, m_op(rs1), m_op(rs2)); else n_pass++;
            tick();
            n_chk++; if (w_req !== m_wreq || sb_err !== m_err)
                $display("FAIL rnd_wstage c%0d: got req=%b err=%b want %b %b", c, w_req, sb_err, m_wreq, m_err); else n_pass++;
            if (m_wreq) begin
                n_chk++; if (w_addr !== m_waddr || w_dat !== m_wdata)
                    $display("FAIL rnd_wdata c%0d: got %0d %h want %0d %h", c, w_addr, w_dat, m_waddr, m_wdata); else n_pass++;
            end
        end
        rst = 0;
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu_raw();
        test_long_load();
        test_priority();
        test_x0_and_unsolicited();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
